// File: rtl/mem_port_arbiter_pkg.sv
// Shared types for the memory port arbiter: bus widths and response tags.
// Tags travel alongside each granted read so the returned word finds its owner.
package mem_port_arbiter_pkg;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 64;
    localparam int STRB_W = DATA_W / 8;

    typedef enum logic {
        OWN_DATA = 1'b0,
        OWN_INST = 1'b1
    } owner_t;

    typedef struct packed {
        logic   valid;
        owner_t owner;
    } rsp_tag_t;

    localparam rsp_tag_t RSP_IDLE = '{valid: 1'b0, owner: OWN_DATA};

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Core-side data/fetch ports plus the single memory port, bundled as one bus.
// slave is the arbiter's view; master is the core/memory side.
interface mem_port_arbiter_if;
    import mem_port_arbiter_pkg::*;

    logic              flush;
    logic              d_req;
    logic [ADDR_W-1:0] d_addr;
    logic [STRB_W-1:0] d_we;
    logic [DATA_W-1:0] d_wdata;
    logic              d_gnt;
    logic              d_rvalid;
    logic [DATA_W-1:0] d_rdata;
    logic              i_req;
    logic [ADDR_W-1:0] i_addr;
    logic              i_gnt;
    logic              i_rvalid;
    logic [DATA_W-1:0] i_rdata;
    logic [ADDR_W-1:0] m_addr;
    logic [STRB_W-1:0] m_we;
    logic [DATA_W-1:0] m_wdata;
    logic [DATA_W-1:0] m_rdata;

    modport slave (
        input  flush, d_req, d_addr, d_we, d_wdata, i_req, i_addr, m_rdata,
        output d_gnt, d_rvalid, d_rdata, i_gnt, i_rvalid, i_rdata,
        output m_addr, m_we, m_wdata
    );

    modport master (
        output flush, d_req, d_addr, d_we, d_wdata, i_req, i_addr, m_rdata,
        input  d_gnt, d_rvalid, d_rdata, i_gnt, i_rvalid, i_rdata,
        input  m_addr, m_we, m_wdata
    );

endinterface

// File: rtl/mem_port_arbiter_rsp_tag_pipe.sv
// Shift register of response tags, one stage per cycle of memory latency.
// Flush kills every in-flight fetch tag, including the one at the output stage.
module mem_port_arbiter_rsp_tag_pipe
    import mem_port_arbiter_pkg::*;
#(
    parameter int DEPTH = 1
) (
    input  logic     clk,
    input  logic     rstn,
    input  rsp_tag_t i_push,
    input  logic     i_flush,
    output logic     o_data_valid,
    output logic     o_inst_valid
);

    rsp_tag_t r_stage [DEPTH];
    rsp_tag_t w_next  [DEPTH];
    rsp_tag_t w_tail;

    // NOTE: every always_comb output gets a value before any branch; a path that leaves it unassigned infers a latch.
    always_comb begin
        w_next[0] = i_push;
        for (int k = 1; k < DEPTH; k++) begin
            w_next[k] = r_stage[k-1];
        end
        for (int k = 0; k < DEPTH; k++) begin
            if (i_flush && (w_next[k].owner == OWN_INST)) begin
                w_next[k].valid = 1'b0;
            end
        end
    end

    // NOTE: sequential state uses <= so every stage samples its neighbour's pre-edge value.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int k = 0; k < DEPTH; k++) begin
                r_stage[k] <= RSP_IDLE;
            end
        end else begin
            for (int k = 0; k < DEPTH; k++) begin
                r_stage[k] <= w_next[k];
            end
        end
    end

    assign w_tail       = r_stage[DEPTH-1];
    assign o_data_valid = w_tail.valid && (w_tail.owner == OWN_DATA);
    assign o_inst_valid = w_tail.valid && (w_tail.owner == OWN_INST) && !i_flush;

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one fixed-latency memory between the data port and the fetch port,
// with data-first priority, a fetch starvation override and flush of fetch responses.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int LOAD_LATENCY = 1,
    parameter int STARVE_MAX   = 4
) (
    input  logic               clk,
    input  logic               rstn,
    mem_port_arbiter_if.slave  bus
);

    localparam int              CNT_W   = $clog2(STARVE_MAX + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_MAX);

    logic [CNT_W-1:0]  r_starve_cnt;
    logic [DATA_W-1:0] r_d_rdata;
    logic [DATA_W-1:0] r_i_rdata;
    logic              w_inst_override;
    logic              w_d_gnt;
    logic              w_i_gnt;
    logic              w_d_rvalid;
    logic              w_i_rvalid;
    rsp_tag_t          w_push;

    // Grants are gated by rstn so the ports go quiet the moment reset asserts.
    assign w_inst_override = rstn && bus.i_req && !bus.flush && (r_starve_cnt == CNT_MAX);
    assign w_d_gnt         = rstn && bus.d_req && !w_inst_override;
    assign w_i_gnt         = rstn && bus.i_req && !bus.flush && !w_d_gnt;

    assign bus.d_gnt = w_d_gnt;
    assign bus.i_gnt = w_i_gnt;

    always_comb begin
        bus.m_addr  = '0;
        bus.m_we    = '0;
        bus.m_wdata = '0;
        if (w_d_gnt) begin
            bus.m_addr  = bus.d_addr;
            bus.m_we    = bus.d_we;
            bus.m_wdata = bus.d_wdata;
        end else if (w_i_gnt) begin
            bus.m_addr  = bus.i_addr;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_starve_cnt <= '0;
        end else if (!bus.i_req || w_i_gnt || bus.flush) begin
            r_starve_cnt <= '0;
        end else if (r_starve_cnt != CNT_MAX) begin
            r_starve_cnt <= r_starve_cnt + 1'b1;
        end
    end

    // Stores complete at grant, so only loads and fetches push a live tag.
    always_comb begin
        w_push       = RSP_IDLE;
        w_push.valid = (w_d_gnt && (bus.d_we == '0)) || w_i_gnt;
        w_push.owner = w_i_gnt ? OWN_INST : OWN_DATA;
    end

    mem_port_arbiter_rsp_tag_pipe #(
        .DEPTH (LOAD_LATENCY)
    ) u_rsp_pipe (
        .clk          (clk),
        .rstn         (rstn),
        .i_push       (w_push),
        .i_flush      (bus.flush),
        .o_data_valid (w_d_rvalid),
        .o_inst_valid (w_i_rvalid)
    );

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_d_rdata <= '0;
            r_i_rdata <= '0;
        end else begin
            if (w_d_rvalid) r_d_rdata <= bus.m_rdata;
            if (w_i_rvalid) r_i_rdata <= bus.m_rdata;
        end
    end

    assign bus.d_rvalid = w_d_rvalid;
    assign bus.i_rvalid = w_i_rvalid;
    assign bus.d_rdata  = w_d_rvalid ? bus.m_rdata : r_d_rdata;
    assign bus.i_rdata  = w_i_rvalid ? bus.m_rdata : r_i_rdata;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: three instances with load latency 1, 2 and 3
// share the same stimulus; each scenario checks the instance it targets.
module tb_mem_port_arbiter;
    import mem_port_arbiter_pkg::*;

    logic clk = 1'b0;
    logic rstn;
    always #5 clk = ~clk;

    logic              t_flush, t_d_req, t_i_req;
    logic [STRB_W-1:0] t_d_we;
    logic [ADDR_W-1:0] t_d_addr, t_i_addr;
    logic [DATA_W-1:0] t_d_wdata, t_m_rdata;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        mem_port_arbiter_if bus ();
        assign bus.flush   = t_flush;
        assign bus.d_req   = t_d_req;
        assign bus.d_addr  = t_d_addr;
        assign bus.d_we    = t_d_we;
        assign bus.d_wdata = t_d_wdata;
        assign bus.i_req   = t_i_req;
        assign bus.i_addr  = t_i_addr;
        assign bus.m_rdata = t_m_rdata;
        mem_port_arbiter #(.LOAD_LATENCY(g + 1), .STARVE_MAX(4)) u_dut (
            .clk  (clk),
            .rstn (rstn),
            .bus  (bus)
        );
    end

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic        d_req;
        logic [7:0]  d_we;
        logic [31:0] d_addr;
        logic [63:0] d_wdata;
        logic        i_req;
        logic [31:0] i_addr;
        logic        flush;
        logic        e_dg;
        logic        e_ig;
        logic [31:0] e_addr;
        logic [7:0]  e_we;
        logic [63:0] e_wdata;
    } vec_t;

    vec_t vecs[$];

    localparam logic [31:0] A_LD = 32'h40;
    localparam logic [31:0] A_ST = 32'h80;
    localparam logic [31:0] A_IF = 32'h100;
    localparam logic [63:0] WD   = 64'hA5A5_5A5A_0F0F_F0F0;

    task automatic add(input logic dr, input logic [7:0] we, input logic [31:0] da, input logic [63:0] wd,
                       input logic ir, input logic [31:0] ia, input logic fl,
                       input logic edg, input logic eig, input logic [31:0] ea, input logic [7:0] ewe,
                       input logic [63:0] ewd);
        vec_t v;
        v = '{dr, we, da, wd, ir, ia, fl, edg, eig, ea, ewe, ewd};
        vecs.push_back(v);
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic set_idle();
        t_flush = 0; t_d_req = 0; t_i_req = 0; t_d_we = '0;
        t_d_addr = '0; t_i_addr = '0; t_d_wdata = '0; t_m_rdata = '0;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) begin
            cyc();
            set_idle();
        end
    endtask

    initial begin
        // Row stimulus with the starvation counter tracked by hand (STARVE_MAX=4).
        add(1, 8'h00, A_LD, 0,  1, A_IF, 0,  1, 0, A_LD, 8'h00, 0);   // cnt 0->1
        add(1, 8'hFF, A_ST, WD, 1, A_IF, 0,  1, 0, A_ST, 8'hFF, WD);  // 1->2
        add(1, 8'h00, A_LD, 0,  1, A_IF, 0,  1, 0, A_LD, 8'h00, 0);   // 2->3
        add(1, 8'h00, A_LD, 0,  1, A_IF, 0,  1, 0, A_LD, 8'h00, 0);   // 3->4
        add(1, 8'h00, A_LD, 0,  1, A_IF, 0,  0, 1, A_IF, 8'h00, 0);   // override, ->0
        add(1, 8'hFF, A_ST, WD, 1, A_IF, 0,  1, 0, A_ST, 8'hFF, WD);
        add(1, 8'h00, A_LD, 0,  1, A_IF, 0,  1, 0, A_LD, 8'h00, 0);
        add(1, 8'h00, A_LD, 0,  1, A_IF, 0,  1, 0, A_LD, 8'h00, 0);
        add(1, 8'h00, A_LD, 0,  1, A_IF, 0,  1, 0, A_LD, 8'h00, 0);
        add(1, 8'hFF, A_ST, WD, 1, A_IF, 0,  0, 1, A_IF, 8'h00, 0);   // losing store drives nothing
        add(0, 8'h00, 0,    0,  1, A_IF, 0,  0, 1, A_IF, 8'h00, 0);
        add(1, 8'hFF, A_ST, WD, 1, A_IF, 1,  1, 0, A_ST, 8'hFF, WD);
        add(0, 8'h00, 0,    0,  1, A_IF, 1,  0, 0, 0,    8'h00, 0);   // flush blocks fetch
        add(0, 8'h00, 0,    0,  0, 0,    0,  0, 0, 0,    8'h00, 0);
        add(1, 8'h00, A_LD, 0,  1, A_IF, 0,  1, 0, A_LD, 8'h00, 0);   // 0->1
        add(1, 8'h00, A_LD, 0,  0, A_IF, 0,  1, 0, A_LD, 8'h00, 0);   // i_req=0 clears
        add(1, 8'h00, A_LD, 0,  1, A_IF, 0,  1, 0, A_LD, 8'h00, 0);
        add(1, 8'h00, A_LD, 0,  1, A_IF, 0,  1, 0, A_LD, 8'h00, 0);
        add(1, 8'h00, A_LD, 0,  1, A_IF, 0,  1, 0, A_LD, 8'h00, 0);
        add(1, 8'h00, A_LD, 0,  1, A_IF, 0,  1, 0, A_LD, 8'h00, 0);   // ->4
        add(1, 8'h00, A_LD, 0,  1, A_IF, 1,  1, 0, A_LD, 8'h00, 0);   // saturated but flush
        add(1, 8'h00, A_LD, 0,  1, A_IF, 0,  1, 0, A_LD, 8'h00, 0);   // counter was cleared

        // Reset state, with live requests held on the inputs.
        rstn = 1'b1;
        set_idle();
        t_d_req = 1; t_d_addr = A_LD; t_d_we = 8'hFF; t_d_wdata = WD;
        t_i_req = 1; t_i_addr = A_IF; t_m_rdata = 64'h1234;
        #1 rstn = 1'b0;
        #2;
        check("rst d_gnt",    g_dut[0].bus.d_gnt,    0);
        check("rst i_gnt",    g_dut[0].bus.i_gnt,    0);
        check("rst m_addr",   g_dut[0].bus.m_addr,   0);
        check("rst m_we",     g_dut[0].bus.m_we,     0);
        check("rst m_wdata",  g_dut[0].bus.m_wdata,  0);
        check("rst d_rvalid", g_dut[0].bus.d_rvalid, 0);
        check("rst i_rvalid", g_dut[0].bus.i_rvalid, 0);
        check("rst d_rdata",  g_dut[0].bus.d_rdata,  0);
        check("rst i_rdata",  g_dut[0].bus.i_rdata,  0);
        @(negedge clk);
        @(negedge clk);
        set_idle();
        rstn = 1'b1;

        // Grant priority, starvation override, flush gating and memory muxing.
        foreach (vecs[i]) begin
            cyc();
            t_d_req = vecs[i].d_req;  t_d_we = vecs[i].d_we;  t_d_addr = vecs[i].d_addr;
            t_d_wdata = vecs[i].d_wdata; t_i_req = vecs[i].i_req; t_i_addr = vecs[i].i_addr;
            t_flush = vecs[i].flush;
            #2;
            check($sformatf("v%0d d_gnt", i),   g_dut[0].bus.d_gnt,   vecs[i].e_dg);
            check($sformatf("v%0d i_gnt", i),   g_dut[0].bus.i_gnt,   vecs[i].e_ig);
            check($sformatf("v%0d m_addr", i),  g_dut[0].bus.m_addr,  vecs[i].e_addr);
            check($sformatf("v%0d m_we", i),    g_dut[0].bus.m_we,    vecs[i].e_we);
            check($sformatf("v%0d m_wdata", i), g_dut[0].bus.m_wdata, vecs[i].e_wdata);
        end
        idle(4);

        // Single load, latency 1.
        cyc(); t_d_req = 1; t_d_addr = 32'h40; #2;
        check("ld1 d_gnt", g_dut[0].bus.d_gnt, 1);
        check("ld1 m_addr", g_dut[0].bus.m_addr, 32'h40);
        cyc(); set_idle(); t_m_rdata = 64'hDEADBEEF_00000001; #2;
        check("ld1 d_rvalid", g_dut[0].bus.d_rvalid, 1);
        check("ld1 d_rdata", g_dut[0].bus.d_rdata, 64'hDEADBEEF_00000001);
        check("ld1 i_rvalid", g_dut[0].bus.i_rvalid, 0);
        cyc(); t_m_rdata = '0; #2;
        check("ld1 pulse end", g_dut[0].bus.d_rvalid, 0);
        check("ld1 rdata hold", g_dut[0].bus.d_rdata, 64'hDEADBEEF_00000001);
        idle(4);

        // Interleaved load/fetch/load, latency 2.
        cyc(); t_d_req = 1; t_d_addr = 32'h10; #2;
        check("mix c0 d_gnt", g_dut[1].bus.d_gnt, 1);
        cyc(); set_idle(); t_i_req = 1; t_i_addr = 32'h20; #2;
        check("mix c1 i_gnt", g_dut[1].bus.i_gnt, 1);
        cyc(); set_idle(); t_d_req = 1; t_d_addr = 32'h30; t_m_rdata = 64'h1; #2;
        check("mix c2 d_gnt", g_dut[1].bus.d_gnt, 1);
        check("mix c2 d_rvalid", g_dut[1].bus.d_rvalid, 1);
        check("mix c2 d_rdata", g_dut[1].bus.d_rdata, 64'h1);
        check("mix c2 i_rvalid", g_dut[1].bus.i_rvalid, 0);
        cyc(); set_idle(); t_m_rdata = 64'h2; #2;
        check("mix c3 i_rvalid", g_dut[1].bus.i_rvalid, 1);
        check("mix c3 i_rdata", g_dut[1].bus.i_rdata, 64'h2);
        check("mix c3 d_rvalid", g_dut[1].bus.d_rvalid, 0);
        cyc(); t_m_rdata = 64'h3; #2;
        check("mix c4 d_rvalid", g_dut[1].bus.d_rvalid, 1);
        check("mix c4 d_rdata", g_dut[1].bus.d_rdata, 64'h3);
        check("mix c4 i_rvalid", g_dut[1].bus.i_rvalid, 0);
        cyc(); t_m_rdata = '0; #2;
        check("mix c5 rvalids", {g_dut[1].bus.d_rvalid, g_dut[1].bus.i_rvalid}, 0);
        check("mix c5 i_rdata hold", g_dut[1].bus.i_rdata, 64'h2);
        idle(4);

        // Store then fetch of the same address, latency 2.
        cyc(); t_d_req = 1; t_d_addr = 32'h80; t_d_we = 8'hFF; t_d_wdata = 64'hCAFEF00D_12345678; #2;
        check("st m_we", g_dut[1].bus.m_we, 8'hFF);
        check("st m_wdata", g_dut[1].bus.m_wdata, 64'hCAFEF00D_12345678);
        cyc(); set_idle(); t_i_req = 1; t_i_addr = 32'h80; #2;
        check("st fetch i_gnt", g_dut[1].bus.i_gnt, 1);
        check("st fetch m_we", g_dut[1].bus.m_we, 0);
        check("st fetch m_addr", g_dut[1].bus.m_addr, 32'h80);
        cyc(); set_idle(); #2;
        check("st no response", {g_dut[1].bus.d_rvalid, g_dut[1].bus.i_rvalid}, 0);
        cyc(); t_m_rdata = 64'hCAFEF00D_12345678; #2;
        check("st fetch i_rvalid", g_dut[1].bus.i_rvalid, 1);
        check("st fetch i_rdata", g_dut[1].bus.i_rdata, 64'hCAFEF00D_12345678);
        check("st fetch d_rvalid", g_dut[1].bus.d_rvalid, 0);
        idle(4);

        // Flush kills in-flight fetches but not the load, latency 3.
        cyc(); t_i_req = 1; t_i_addr = 32'h200; #2;
        check("fl c0 i_gnt", g_dut[2].bus.i_gnt, 1);
        cyc(); t_i_addr = 32'h204; #2;
        check("fl c1 i_gnt", g_dut[2].bus.i_gnt, 1);
        cyc(); set_idle(); t_d_req = 1; t_d_addr = 32'h300; #2;
        check("fl c2 d_gnt", g_dut[2].bus.d_gnt, 1);
        cyc(); set_idle(); t_flush = 1; t_i_req = 1; t_i_addr = 32'h208; t_m_rdata = 64'h55; #2;
        check("fl c3 i_gnt", g_dut[2].bus.i_gnt, 0);
        check("fl c3 i_rvalid", g_dut[2].bus.i_rvalid, 0);
        cyc(); set_idle(); t_m_rdata = 64'h66; #2;
        check("fl c4 i_rvalid", g_dut[2].bus.i_rvalid, 0);
        check("fl c4 d_rvalid", g_dut[2].bus.d_rvalid, 0);
        cyc(); t_m_rdata = 64'h77; #2;
        check("fl c5 d_rvalid", g_dut[2].bus.d_rvalid, 1);
        check("fl c5 d_rdata", g_dut[2].bus.d_rdata, 64'h77);
        check("fl c5 i_rvalid", g_dut[2].bus.i_rvalid, 0);
        idle(4);

        // Reset asserted while loads are in flight.
        cyc(); t_d_req = 1; t_d_addr = 32'h40; #2;
        check("rm d_gnt", g_dut[2].bus.d_gnt, 1);
        @(posedge clk); #2;
        t_m_rdata = 64'h99;
        #1;
        check("rm lat1 d_rvalid", g_dut[0].bus.d_rvalid, 1);
        #1 rstn = 1'b0;
        #1;
        check("rm lat1 d_rvalid off", g_dut[0].bus.d_rvalid, 0);
        check("rm lat1 d_rdata", g_dut[0].bus.d_rdata, 0);
        check("rm d_gnt off", g_dut[2].bus.d_gnt, 0);
        check("rm m_addr", g_dut[2].bus.m_addr, 0);
        check("rm d_rdata", g_dut[2].bus.d_rdata, 0);
        @(posedge clk);
        @(negedge clk);
        set_idle();
        rstn = 1'b1;
        for (int k = 0; k < 5; k++) begin
            cyc(); #2;
            check($sformatf("rm post %0d rvalid", k),
                  {g_dut[0].bus.d_rvalid, g_dut[0].bus.i_rvalid, g_dut[1].bus.d_rvalid,
                   g_dut[1].bus.i_rvalid, g_dut[2].bus.d_rvalid, g_dut[2].bus.i_rvalid}, 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
Shares one single-ported, fixed-latency memory between the core's data port (load/store from the execute phase) and its instruction-fetch port.
- Grants one requester per cycle.
- Tags each granted read and routes the returned word to its owner exactly LOAD_LATENCY cycles later.
- Prevents fetch starvation with a saturating wait counter.
- Honours pipeline flush by discarding in-flight fetch responses.

Parameters:
LOAD_LATENCY, 1, memory read latency in cycles from address presentation to m_rdata valid (legal range 1..8)
STARVE_MAX, 4, consecutive cycles a fetch may wait before it overrides data priority (>=1)

Ports:
clk  in  1  clock
rstn  in  1  reset, asynchronous, active-low
flush  in  1  pipeline flush from write-back phase
d_req  in  1  data request, held until d_gnt
d_addr  in  `ADDR_W  data byte address
d_we  in  `DATA_W/8  byte write enables; all zero means load
d_wdata  in  `DATA_W  store data
d_gnt  out  1  data request accepted this cycle
d_rvalid  out  1  load data valid pulse
d_rdata  out  `DATA_W  load data
i_req  in  1  fetch request, held until i_gnt
i_addr  in  `ADDR_W  fetch address
i_gnt  out  1  fetch accepted this cycle
i_rvalid  out  1  fetch data valid pulse
i_rdata  out  `DATA_W  fetch data
m_addr  out  `ADDR_W  memory address
m_we  out  `DATA_W/8  memory byte write enables
m_wdata  out  `DATA_W  memory write data
m_rdata  in  `DATA_W  memory read data (LOAD_LATENCY after address)

Behaviour:
- Reset (rstn=0, asynchronous):
  - Response pipeline cleared, starvation counter=0.
  - d_gnt=i_gnt=0, d_rvalid=i_rvalid=0, m_we=0, m_addr=0, m_wdata=0, d_rdata=i_rdata=0.
  - Anything in flight at reset assertion is lost; no rvalid is produced for it after reset release.
- Grant (combinational, same cycle as request):
  - Default priority is data over fetch.
  - Fetch wins instead when i_req=1 and starve_cnt==STARVE_MAX.
  - During a flush cycle i_gnt=0 and data may be granted normally.
  - Exactly one of d_gnt/i_gnt or neither; never both.
- Memory drive:
  - m_addr/m_we/m_wdata are the winner's address/enables/data.
  - With no grant: m_we=0, m_addr=0, m_wdata=0.
  - For a fetch grant m_we=0 always.
- Starvation counter, width $clog2(STARVE_MAX+1):
  - Cleared when i_gnt=1, when i_req=0, or when flush=1.
  - Otherwise increments on each cycle with i_req=1 and i_gnt=0, saturating at STARVE_MAX.
- Response pipeline: shift register, depth LOAD_LATENCY, entries {valid, owner}.
  - A granted load (d_gnt with d_we==0) pushes {1,DATA}.
  - A granted fetch pushes {1,INST}.
  - A store or idle cycle pushes {0,-}.
  - Output stage: valid&&owner==DATA gives d_rvalid=1, d_rdata=m_rdata. valid&&owner==INST gives i_rvalid=1, i_rdata=m_rdata.
  - Non-selected rdata holds its last value. Pulses last exactly one cycle.
  - Load-to-rvalid latency = LOAD_LATENCY cycles; order preserved; no back-pressure on responses.
- Flush:
  - Clears valid on every in-flight INST entry, including one granted in the cycle before flush.
  - An INST entry reaching the output stage in the flush cycle is suppressed (i_rvalid=0).
  - DATA entries are unaffected.
- Stores complete at grant; no response.
- Read-after-write to the same address is ordered by grant order; the memory provides write-first semantics.
- Simultaneous d_req and i_req with starve_cnt<STARVE_MAX: data wins, counter increments.

Decomposition:
- Shared package (core_pkg alongside common_params.h):
  - typedef owner_t (enum OWN_DATA, OWN_INST)
  - typedef rsp_tag_t {logic valid; owner_t owner;}
  - Address and data widths come from `ADDR_W/`DATA_W.
- One natural sub-module: rsp_tag_pipe (parameterised depth, push/flush-by-owner, output stage). Arbitration and muxing stay in the top.

Test Plan:
1. Reset mid-traffic: d_req load granted at cycle 5, rstn=0 at cycle 5.5 -> all outputs 0 immediately, no d_rvalid after release.
2. Data load at addr 0x40 with m_rdata=0xDEADBEEF_00000001, LOAD_LATENCY=1 -> d_gnt same cycle, d_rvalid=1 with that value exactly 1 cycle later, i_rvalid=0.
3. Continuous d_req and i_req, STARVE_MAX=4 -> grant pattern D,D,D,D,I repeating, counter resets after each I, and no cycle has both grants.
4. Store d_we=0xFF to 0x80, then fetch at 0x80 next cycle -> m_we=0xFF on cycle 0 and m_we=0 on cycle 1, no d_rvalid, i_rvalid carries stored data, LOAD_LATENCY cycles after the fetch grant.
5. LOAD_LATENCY=3: fetch granted cycles 0,1, load cycle 2, flush cycle 3 -> both fetch responses suppressed, d_rvalid at cycle 5, i_req on cycle 3 not granted.
6. Interleaved load/fetch/load with LOAD_LATENCY=2 -> rvalids at cycles 2,3,4 routed D,I,D with matching m_rdata words 0x1,0x2,0x3.
